window_sched: RTL and testbench
===============================

WINDOW_SCHED -- requirements
Module: window_sched

Interface
REQ-001 Parameter DW, default 12: pixel width in bits; equals the Sobel datapath DW.
REQ-002 Parameter LINE_W, default 640: pixels per line; legal range 4..4096.
REQ-003 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 i_rstn  input  1  reset: synchronous, active-low.
REQ-005 i_data  input  DW  upstream pixel.
REQ-006 i_valid  input  1  upstream pixel valid.
REQ-007 o_ready  output  1  upstream ready; a pixel is accepted when i_valid & o_ready.
REQ-008 i_sof  input  1  start-of-frame; qualified by pixel acceptance.
REQ-009 o_window  output  9*DW  3x3 window to the Sobel datapath.
REQ-010 o_window_valid  output  1  window valid, single-cycle per window.

Function
REQ-011 Storage SHALL be four line buffers LB0..LB3 of LINE_W x DW, each synchronous-read RAM.
REQ-012 Each accepted pixel SHALL be written to LB[wsel][wcol]; wcol SHALL increment and wrap LINE_W-1 -> 0; on wrap, wsel SHALL increment mod 4 and fill_cnt SHALL increment.
REQ-013 o_ready SHALL be 1 iff fill_cnt < 4.
REQ-014 The FSM SHALL have states IDLE, PRIME, STREAM and ADVANCE.
REQ-015 IDLE -> PRIME when fill_cnt >= 3; otherwise stay in IDLE.
REQ-016 PRIME SHALL read columns 0 and 1 of LB[rsel], LB[rsel+1] and LB[rsel+2] (mod 4) over 2 cycles, then go to STREAM.
REQ-017 STREAM SHALL read columns 2..LINE_W-1, one per cycle, then go to ADVANCE.
REQ-018 ADVANCE SHALL last 1 cycle: rsel += 1 mod 4, fill_cnt -= 1, then go to IDLE.
REQ-019 If a line completes in the ADVANCE cycle, fill_cnt SHALL be unchanged (net +1 -1).
REQ-020 Each row SHALL keep a 3-deep column shift register fed by its RAM read data; one window SHALL be emitted per STREAM read; exactly LINE_W-2 windows per line pass.
REQ-021 Packing: o_window[(3*r+c)*DW +: DW], where r = 0 is the oldest line (rsel), c = 0 is the leftmost column.
REQ-022 Latency: a STREAM read issued in cycle n SHALL appear on o_window / o_window_valid in cycle n+2; all outputs are registered.
REQ-023 i_sof on an accepted pixel SHALL:
  - write that pixel to LB0 column 0 (wsel = 1'b0 ... i.e. wsel = 0, wcol = 1 after the write);
  - clear fill_cnt, rsel and the shift registers;
  - force the FSM to IDLE;
  - drop in-flight windows, so o_window_valid = 0 from the next cycle.
REQ-024 i_sof with i_valid = 0, or with o_ready = 0, SHALL be ignored.
REQ-025 There is no downstream backpressure; the Sobel datapath always accepts.

Reset
REQ-026 With i_rstn low at a clock edge, reset SHALL clear:
  - fill_cnt, wsel, wcol, rsel and rcol to 0;
  - the FSM to IDLE;
  - o_window_valid to 0 and o_window to 0;
  - o_ready to 1 from the first cycle after reset.
REQ-027 Reset asserted mid-line or mid-STREAM SHALL abandon the frame; no window emits until 3 new lines are written.
REQ-028 RAM contents are not reset.

Configuration
REQ-029 Macro WINDOW_SCHED_STATS_EN defined:
  - adds output o_win_cnt [19:0], the count of windows emitted since reset or the last accepted i_sof;
  - the count saturates at 20'hFFFFF;
  - it is registered, so it updates the cycle after o_window_valid.
REQ-030 Macro WINDOW_SCHED_STATS_EN undefined: port and counter are absent; behaviour is otherwise identical.

Verification (LINE_W = 8, DW = 12, pixel value = 16*row + col)
REQ-031 Reset:
  - stimulus: hold i_rstn low 3 cycles, then release;
  - required: o_ready = 1, o_window_valid = 0, o_window = 0.
REQ-032 First window:
  - stimulus: i_sof on the first pixel; 24 pixels at 1/cycle; T = cycle of the last acceptance;
  - required: first o_window_valid at T+6, o_window = {34,33,32,18,17,16,2,1,0} (MSB..LSB);
  - then 6 consecutive valids, the last with c0 = 5.
REQ-033 Stall:
  - stimulus: continuous i_valid = 1;
  - required: o_ready falls when fill_cnt reaches 4;
  - o_ready returns to 1 the cycle after ADVANCE;
  - no pixel is lost; window rows continue 16,32,48, ...
REQ-034 Simultaneous events:
  - stimulus: line 4 completes in the ADVANCE cycle of line pass 1;
  - required: fill_cnt stays 3; the next PRIME starts 1 cycle later.
REQ-035 Mid-frame restart:
  - stimulus: i_sof during STREAM;
  - required: o_window_valid = 0 from the next cycle; the next window appears only after 3 new lines, with top-left = the i_sof pixel.
REQ-036 Stats (WINDOW_SCHED_STATS_EN defined):
  - stimulus: 5 lines;
  - required: o_win_cnt = 18; an i_sof clears it to 0.

Source files
------------

// File: rtl/window_sched.sv
// window_sched: four line buffers feeding a 3x3 window stream to the Sobel datapath.
// Define WINDOW_SCHED_STATS_EN to add o_win_cnt, a saturating count of emitted windows.
module window_sched #(
    parameter int DW     = 12,
    parameter int LINE_W = 640
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [DW-1:0]   i_data,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_sof,
    output logic [9*DW-1:0] o_window,
    output logic            o_window_valid
`ifdef WINDOW_SCHED_STATS_EN
    ,
    output logic [19:0]     o_win_cnt
`endif
);

    localparam int CW = $clog2(LINE_W);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRIME   = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;
    localparam logic [1:0] S_ADVANCE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    wsel;
    logic [CW-1:0] wcol;
    logic [2:0]    fill_cnt;
    logic [2:0]    fill_nxt;
    logic [1:0]    rsel;
    logic [CW-1:0] rcol;

    logic          accept;
    logic          sof_acc;
    logic          line_done;
    logic          in_adv;
    logic          rd_en;
    logic          rd_stream;
    logic [1:0]    wr_sel;
    logic [CW-1:0] wr_col;

    logic          rd_vld_q;
    logic          rd_str_q;
    logic [3:0][DW-1:0] rd_data;
    logic [2:0][DW-1:0] row_data;

    assign accept    = i_valid & o_ready;
    assign sof_acc   = accept & i_sof;
    assign line_done = accept & ~i_sof & (wcol == COL_LAST);
    assign in_adv    = (state == S_ADVANCE);
    assign rd_en     = (state == S_PRIME) | (state == S_STREAM);
    assign rd_stream = (state == S_STREAM);

    // A start-of-frame pixel always lands in LB0 column 0.
    assign wr_sel = sof_acc ? 2'd0 : wsel;
    assign wr_col = sof_acc ? '0 : wcol;

    // A line completing during ADVANCE cancels the decrement.
    always_comb begin
        // NOTE: default first so every path assigns fill_nxt and no latch is inferred.
        fill_nxt = fill_cnt;
        if (sof_acc)
            fill_nxt = '0;
        else if (line_done && !in_adv)
            fill_nxt = fill_cnt + 3'd1;
        else if (!line_done && in_adv)
            fill_nxt = fill_cnt - 3'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wsel     <= 2'd0;
            wcol     <= '0;
            fill_cnt <= 3'd0;
            o_ready  <= 1'b1;
        end else begin
            fill_cnt <= fill_nxt;
            o_ready  <= (fill_nxt < 3'd4);
            if (sof_acc) begin
                wsel <= 2'd0;
                wcol <= CW'(1);
            end else if (accept) begin
                if (wcol == COL_LAST) begin
                    wcol <= '0;
                    wsel <= wsel + 2'd1;
                end else begin
                    wcol <= wcol + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lb
        logic [DW-1:0] mem [LINE_W];
        logic [DW-1:0] lb_q;

        // NOTE: RAM contents are deliberately not reset; stale data is never read because
        // a line pass only starts once three fresh lines have been written.
        always_ff @(posedge i_clk) begin
            if (accept && wr_sel == 2'(b))
                mem[wr_col] <= i_data;
            if (rd_en)
                lb_q <= mem[rcol];
        end

        assign rd_data[b] = lb_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= S_IDLE;
            rsel  <= 2'd0;
            rcol  <= '0;
        end else if (sof_acc) begin
            state <= S_IDLE;
            rsel  <= 2'd0;
            rcol  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fill_cnt >= 3'd3) begin
                        state <= S_PRIME;
                        rcol  <= '0;
                    end
                end
                S_PRIME: begin
                    rcol <= rcol + 1'b1;
                    if (rcol == CW'(1))
                        state <= S_STREAM;
                end
                S_STREAM: begin
                    if (rcol == COL_LAST) begin
                        rcol  <= '0;
                        state <= S_ADVANCE;
                    end else begin
                        rcol <= rcol + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    rsel  <= rsel + 2'd1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_vld_q <= 1'b0;
            rd_str_q <= 1'b0;
        end else if (sof_acc) begin
            rd_vld_q <= 1'b0;
            rd_str_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
            rd_str_q <= rd_stream;
        end
    end

    // rsel only moves at the end of ADVANCE, after the last read data has been consumed.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < 3; r++)
            row_data[r] = rd_data[rsel + 2'(r)];
    end

    // o_window itself is the per-row 3-deep column shift register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_window       <= '0;
            o_window_valid <= 1'b0;
        end else if (sof_acc) begin
            o_window       <= '0;
            o_window_valid <= 1'b0;
        end else begin
            o_window_valid <= rd_str_q;
            if (rd_vld_q) begin
                for (int r = 0; r < 3; r++) begin
                    o_window[(3*r)*DW +: DW]   <= o_window[(3*r+1)*DW +: DW];
                    o_window[(3*r+1)*DW +: DW] <= o_window[(3*r+2)*DW +: DW];
                    o_window[(3*r+2)*DW +: DW] <= row_data[r];
                end
            end
        end
    end

`ifdef WINDOW_SCHED_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_win_cnt <= 20'd0;
        end else if (sof_acc) begin
            o_win_cnt <= 20'd0;
        end else if (o_window_valid && o_win_cnt != 20'hFFFFF) begin
            o_win_cnt <= o_win_cnt + 20'd1;
        end
    end
`else
    // Statistics disabled: no counter and no o_win_cnt port.
`endif

endmodule

// File: tb/tb_window_sched.sv
// tb_window_sched: directed bench for window_sched with LINE_W = 8, DW = 12,
// pixel value = base + 16*row + col within each frame.
module tb_window_sched;

    localparam int DW     = 12;
    localparam int LINE_W = 8;
    localparam int WPL    = LINE_W - 2;

    logic            i_clk   = 1'b0;
    logic            i_rstn  = 1'b0;
    logic            i_valid = 1'b0;
    logic            i_sof   = 1'b0;
    logic [DW-1:0]   i_data  = '0;
    logic            o_ready;
    logic            o_window_valid;
    logic [9*DW-1:0] o_window;
`ifdef WINDOW_SCHED_STATS_EN
    logic [19:0]     o_win_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int win_cnt_m;
    int pix_cnt;
    int run_base;
    int valid_cyc [64];
    int acc_cyc   [64];
    logic [9*DW-1:0] win_h [64];
    logic ready_h [128];
    logic valid_h [128];

    window_sched #(.DW(DW), .LINE_W(LINE_W)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_sof          (i_sof),
        .o_window       (o_window),
`ifdef WINDOW_SCHED_STATS_EN
        .o_win_cnt      (o_win_cnt),
`endif
        .o_window_valid (o_window_valid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] pix(input int base, input int n);
        return DW'(base + 16 * (n / LINE_W) + n % LINE_W);
    endfunction

    // Window w of a frame: line pass w/WPL, leftmost column w%WPL.
    function automatic logic [9*DW-1:0] exp_window(input int base, input int w);
        logic [9*DW-1:0] v;
        int p;
        int j;
        p = w / WPL;
        j = w % WPL;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(3*r+c)*DW +: DW] = DW'(base + 16 * (p + r) + (j + c));
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_checks++;
        assert (obs === want) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, want);
        end
    endtask

    task automatic observe(input int c);
        if (c < 128) begin
            ready_h[c] = o_ready;
            valid_h[c] = o_window_valid;
        end
        if (o_window_valid === 1'b1) begin
            if (win_cnt_m < 64) begin
                valid_cyc[win_cnt_m] = c;
                win_h[win_cnt_m]     = o_window;
            end
            check("window", 128'(o_window), 128'(exp_window(run_base, win_cnt_m)));
            win_cnt_m++;
        end
    endtask

    // Offers pixels back to back; pixel hold_n is withheld until cycle hold_until.
    // Cycle 0 is the first driven cycle; observations are indexed by the cycle they belong to.
    task automatic run(input int n_pix, input int base, input bit use_sof,
                       input int hold_n, input int hold_until, input int n_cyc);
        int   n;
        logic v;
        logic acc;
        n         = 0;
        win_cnt_m = 0;
        run_base  = base;
        for (int i = 0; i < 64; i++) begin
            valid_cyc[i] = -1;
            acc_cyc[i]   = -1;
        end
        for (int i = 0; i < 128; i++) begin
            ready_h[i] = 1'bx;
            valid_h[i] = 1'bx;
        end
        ready_h[0] = o_ready;
        valid_h[0] = o_window_valid;
        for (int c = 0; c < n_cyc; c++) begin
            v       = (n < n_pix) && !(n == hold_n && c < hold_until);
            i_valid = v;
            i_sof   = v && use_sof && (n == 0);
            i_data  = pix(base, n);
            acc     = v && (o_ready === 1'b1);
            @(posedge i_clk);
            #1;
            if (acc) begin
                if (n < 64)
                    acc_cyc[n] = c;
                n++;
            end
            observe(c + 1);
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        pix_cnt = n;
    endtask

    initial begin
        // Reset held for three edges, then released.
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", 128'(o_ready), 128'(1'b1));
        check("rst_valid", 128'(o_window_valid), 128'(1'b0));
        check("rst_window", 128'(o_window), 128'(0));
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;
        check("post_rst_ready", 128'(o_ready), 128'(1'b1));
        check("post_rst_valid", 128'(o_window_valid), 128'(1'b0));
        check("post_rst_window", 128'(o_window), 128'(0));

        // Continuous stream of 6 lines: first window latency, stall and refill.
        run(48, 0, 1'b1, -1, 0, 75);
        check("A_last_accept", 128'(acc_cyc[23]), 128'(23));
        check("A_first_valid", 128'(valid_cyc[0]), 128'(acc_cyc[23] + 6));
        check("A_first_win", 128'(win_h[0]),
              128'({12'd34, 12'd33, 12'd32, 12'd18, 12'd17, 12'd16, 12'd2, 12'd1, 12'd0}));
        check("A_run_of_6", 128'(valid_cyc[5]), 128'(34));
        check("A_gap_after_6", 128'(valid_h[35]), 128'(1'b0));
        check("A_last_c0", 128'(win_h[5][DW-1:0]), 128'(5));
        check("A_ready_31", 128'(ready_h[31]), 128'(1'b1));
        check("A_ready_fall", 128'(ready_h[32]), 128'(1'b0));
        check("A_ready_adv", 128'(ready_h[33]), 128'(1'b0));
        check("A_ready_back", 128'(ready_h[34]), 128'(1'b1));
        check("A_pixels", 128'(pix_cnt), 128'(48));
        check("A_windows", 128'(win_cnt_m), 128'(24));

        // Line 4 completes exactly in the ADVANCE cycle of line pass 1.
        run(40, 0, 1'b1, 39, 43, 70);
        check("B_resume", 128'(acc_cyc[32]), 128'(34));
        check("B_line4_in_adv", 128'(acc_cyc[39]), 128'(43));
        check("B_ready_after_adv", 128'(ready_h[44]), 128'(1'b1));
        check("B_pass2_start", 128'(valid_cyc[12]), 128'(49));
        check("B_windows", 128'(win_cnt_m), 128'(18));
`ifdef WINDOW_SCHED_STATS_EN
        check("B_stats", 128'(o_win_cnt), 128'(18));
`endif

        // Restart with i_sof while pass 0 is streaming.
        run(48, 0, 1'b1, -1, 0, 28);
        check("C_no_early_win", 128'(win_cnt_m), 128'(0));
`ifdef WINDOW_SCHED_STATS_EN
        check("C_stats_clear", 128'(o_win_cnt), 128'(0));
`endif
        run(24, 'h400, 1'b1, -1, 0, 40);
        check("C_drop", 128'(valid_h[1]), 128'(1'b0));
        check("C_windows", 128'(win_cnt_m), 128'(6));
        check("C_first_valid", 128'(valid_cyc[0]), 128'(29));
        check("C_top_left", 128'(win_h[0][DW-1:0]), 128'('h400));
`ifdef WINDOW_SCHED_STATS_EN
        check("C_stats", 128'(o_win_cnt), 128'(6));
`endif

        // Reset mid-STREAM abandons the frame; a fresh frame without i_sof follows.
        run(48, 'h800, 1'b1, -1, 0, 28);
        i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        check("D_rst_ready", 128'(o_ready), 128'(1'b1));
        check("D_rst_valid", 128'(o_window_valid), 128'(1'b0));
        check("D_rst_window", 128'(o_window), 128'(0));
        run(24, 'hC00, 1'b0, -1, 0, 40);
        check("D_windows", 128'(win_cnt_m), 128'(6));
        check("D_first_valid", 128'(valid_cyc[0]), 128'(29));
        check("D_top_left", 128'(win_h[0][DW-1:0]), 128'('hC00));
`ifdef WINDOW_SCHED_STATS_EN
        check("D_stats", 128'(o_win_cnt), 128'(6));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
